// File: rtl/riscv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared definitions for the instruction fetch stage: default address width,
// default reset PC, the canonical NOP encoding and the fetch FSM state type.
// ---------------------------------------------------------------------------
package riscv_fetch_pkg;

   localparam int                FETCH_XLEN      = 64;
   localparam logic [63:0]       FETCH_RESET_PC  = 64'h0;
   // ADDI x0,x0,0 -- shown on the IF/ID instruction bus whenever it is empty.
   localparam logic [31:0]       FETCH_NOP_INSTR = 32'h0000_0013;

   // IDLE : one cycle after reset, before the first request
   // REQ  : request asserted, waiting for the memory to accept it
   // WAIT : request accepted, waiting for its single response
   // FULL : response parked in the skid entry because decode is stalled
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FULL = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_id_pipeline_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipeline_reg
// IF/ID pipeline register with flush > stall > load priority.
//   flush          : empties the register (valid=0, NOP), even when stalled
//   stall          : holds every output
//   load_valid     : a real instruction is delivered this cycle; without it
//                    a bubble (valid=0, NOP) is inserted
//   load_pc/instr  : the delivered instruction and its PC
//   if_id_*        : registered outputs toward decode; pc_plus4 is kept as
//                    its own register so the link value costs no adder
//                    in the decode stage
// ---------------------------------------------------------------------------
module if_id_pipeline_reg #(
   parameter int          XLEN      = 64,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            stall,
   input  logic            load_valid,
   input  logic [XLEN-1:0] load_pc,
   input  logic [31:0]     load_instr,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [31:0]     if_id_instr
);

   logic            valid_reg;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_plus4_reg;
   logic [31:0]     instr_reg;

   // A flush or bubble only invalidates the entry and forces the NOP;
   // the PC fields simply keep their last value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg    <= 1'b0;
         pc_reg       <= '0;
         pc_plus4_reg <= XLEN'(4);
         instr_reg    <= NOP_INSTR;
      end else if (flush) begin
         valid_reg <= 1'b0;
         instr_reg <= NOP_INSTR;
      end else if (!stall) begin
         if (load_valid) begin
            valid_reg    <= 1'b1;
            pc_reg       <= load_pc;
            pc_plus4_reg <= load_pc + XLEN'(4);
            instr_reg    <= load_instr;
         end else begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
         end
      end
   end

   assign if_id_valid    = valid_reg;
   assign if_id_pc       = pc_reg;
   assign if_id_pc_plus4 = pc_plus4_reg;
   assign if_id_instr    = instr_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: generates the PC, fetches 32-bit words from instruction
// memory (valid/ready request, valid-only response, at most one request in
// flight) and feeds the IF/ID register consumed by decode.
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   stall               : hazard unit asks IF/ID to hold
//   redirect_valid/_pc  : taken branch/jump from execute; flush and refetch
//   imem_req_*          : request port (valid, ready, addr)
//   imem_rsp_*          : response port (valid, data)
//   if_id_*             : IF/ID register outputs (valid, pc, pc+4, instr)
// ---------------------------------------------------------------------------
module instruction_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter int               XLEN      = FETCH_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC  = FETCH_RESET_PC[XLEN-1:0],
   parameter logic [31:0]      NOP_INSTR = FETCH_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [31:0]     if_id_instr
);

   fetch_state_t    state_reg,      state_next;
   logic [XLEN-1:0] req_addr_reg,   req_addr_next;
   logic [XLEN-1:0] next_pc_reg,    next_pc_next;
   logic            drop_reg,       drop_next;
   logic [31:0]     skid_instr_reg, skid_instr_next;
   logic [XLEN-1:0] skid_pc_reg,    skid_pc_next;

   logic            deliver_valid;
   logic [XLEN-1:0] deliver_pc;
   logic [31:0]     deliver_instr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         req_addr_reg   <= RESET_PC;
         next_pc_reg    <= RESET_PC;
         drop_reg       <= 1'b0;
         skid_instr_reg <= NOP_INSTR;
         skid_pc_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         req_addr_reg   <= req_addr_next;
         next_pc_reg    <= next_pc_next;
         drop_reg       <= drop_next;
         skid_instr_reg <= skid_instr_next;
         skid_pc_reg    <= skid_pc_next;
      end
   end

   // req_addr only changes when leaving WAIT/FULL, so it is stable for the
   // whole time a request is up and, while in WAIT, it is the PC of the
   // instruction in flight.
   always_comb begin
      state_next      = state_reg;
      req_addr_next   = req_addr_reg;
      next_pc_next    = next_pc_reg;
      drop_next       = drop_reg;
      skid_instr_next = skid_instr_reg;
      skid_pc_next    = skid_pc_reg;
      deliver_valid   = 1'b0;
      deliver_pc      = req_addr_reg;
      deliver_instr   = imem_rsp_data;
      imem_req_valid  = 1'b0;

      case (state_reg)
         IDLE: begin
            state_next = REQ;
            if (redirect_valid) begin
               next_pc_next = redirect_pc;
            end
         end

         REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               state_next = WAIT;
               // An earlier redirect already parked its target in next_pc;
               // the sequential +4 must not overwrite it.
               if (!drop_reg) begin
                  next_pc_next = req_addr_reg + XLEN'(4);
               end
            end
            // A request is never withdrawn: its response is dropped instead.
            if (redirect_valid) begin
               next_pc_next = redirect_pc;
               drop_next    = 1'b1;
            end
         end

         WAIT: begin
            if (imem_rsp_valid) begin
               state_next = REQ;
               drop_next  = 1'b0;
               if (redirect_valid) begin
                  next_pc_next  = redirect_pc;
                  req_addr_next = redirect_pc;
               end else if (drop_reg) begin
                  req_addr_next = next_pc_reg;
               end else if (!stall) begin
                  deliver_valid = 1'b1;
                  req_addr_next = next_pc_reg;
               end else begin
                  skid_instr_next = imem_rsp_data;
                  skid_pc_next    = req_addr_reg;
                  state_next      = FULL;
               end
            end else if (redirect_valid) begin
               next_pc_next = redirect_pc;
               drop_next    = 1'b1;
            end
         end

         FULL: begin
            deliver_pc    = skid_pc_reg;
            deliver_instr = skid_instr_reg;
            if (redirect_valid) begin
               next_pc_next  = redirect_pc;
               req_addr_next = redirect_pc;
               state_next    = REQ;
            end else if (!stall) begin
               deliver_valid = 1'b1;
               req_addr_next = next_pc_reg;
               state_next    = REQ;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign imem_req_addr = req_addr_reg;

   if_id_pipeline_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk            (clk),
      .reset          (reset),
      .flush          (redirect_valid),
      .stall          (stall),
      .load_valid     (deliver_valid),
      .load_pc        (deliver_pc),
      .load_instr     (deliver_instr),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. The instruction memory returns
// 32'hA000_0000 | addr one cycle after acceptance (or later when the response
// is deliberately held back). Expected values below are written out by hand.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] INS_A = 32'hA000_0000;
   localparam logic [31:0] INS_B = 32'hA000_0004;
   localparam logic [31:0] INS_C = 32'hA000_0008;
   localparam logic [31:0] INS_T = 32'hA000_0100;

   logic        clk            = 1'b0;
   logic        reset          = 1'b0;
   logic        stall          = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc    = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [63:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;

   int          vectors     = 0;
   int          miscompares = 0;

   logic        pend      = 1'b0;
   logic [63:0] pend_addr = '0;
   logic        rsp_auto  = 1'b1;

   instruction_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
      end else begin
         $display("[%0t] ok   %s = 0x%0h", $time, tag, got);
      end
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [63:0] pc,
                             input logic [63:0] pc4, input logic [31:0] ins);
      check({tag, "_valid"}, if_id_valid, v);
      check({tag, "_pc"}, if_id_pc, pc);
      check({tag, "_pc4"}, if_id_pc_plus4, pc4);
      check({tag, "_instr"}, if_id_instr, ins);
   endtask

   task automatic check_req(input string tag, input logic v, input logic [63:0] addr);
      check({tag, "_req_valid"}, imem_req_valid, v);
      if (v) check({tag, "_req_addr"}, imem_req_addr, addr);
   endtask

   // Advance one clock; inputs and samples are handled 1 time unit after the
   // edge. The memory side-model answers a request one cycle after it is
   // accepted unless rsp_auto is low.
   task automatic step();
      logic        hs;
      logic [63:0] a;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (hs) begin
         pend      = 1'b1;
         pend_addr = a;
      end
      if (pend && rsp_auto) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hA000_0000 | pend_addr[31:0];
         pend           = 1'b0;
      end
   endtask

   initial begin
      // ---- reset values ----
      repeat (2) @(posedge clk);
      #1;
      check_req("rst", 1'b0, 64'h0);
      check_ifid("rst", 1'b0, 64'h0, 64'h4, NOP);
      reset = 1'b1;

      // ---- IDLE -> REQ, memory not ready for 3 cycles ----
      step();
      check_req("req0", 1'b1, 64'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_req("req0_hold", 1'b1, 64'h0);
      end
      imem_req_ready = 1'b1;

      // ---- A, B, C with 1-cycle latency ----
      step();
      check_req("wait0", 1'b0, 64'h0);
      check("bubble0_valid", if_id_valid, 1'b0);
      step();
      check_ifid("A", 1'b1, 64'h0, 64'h4, INS_A);
      check_req("req4", 1'b1, 64'h4);
      step();
      check("bubble1_valid", if_id_valid, 1'b0);
      check("bubble1_instr", if_id_instr, NOP);
      step();
      check_ifid("B", 1'b1, 64'h4, 64'h8, INS_B);
      step();
      check("bubble2_valid", if_id_valid, 1'b0);
      step();
      check_ifid("C", 1'b1, 64'h8, 64'hC, INS_C);
      check_req("reqC", 1'b1, 64'hC);

      // ---- reset asserted mid-WAIT ----
      rsp_auto = 1'b0;
      step();
      check_req("waitC", 1'b0, 64'h0);
      reset = 1'b0;
      #1;
      check_req("rst2", 1'b0, 64'h0);
      check_ifid("rst2", 1'b0, 64'h0, 64'h4, NOP);
      pend     = 1'b0;
      rsp_auto = 1'b1;
      step();
      reset = 1'b1;
      step();
      check_req("rst2_req0", 1'b1, 64'h0);

      // ---- stall while the 0x4 response arrives ----
      step();
      step();
      check_ifid("A2", 1'b1, 64'h0, 64'h4, INS_A);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall_hold", 1'b1, 64'h0, 64'h4, INS_A);
         check_req("stall_noreq", 1'b0, 64'h0);
      end
      stall = 1'b0;
      step();
      check_ifid("B2", 1'b1, 64'h4, 64'h8, INS_B);
      check_req("req8", 1'b1, 64'h8);

      // ---- redirect during WAIT for 0x8 ----
      rsp_auto = 1'b0;
      step();
      check("wait8_valid", if_id_valid, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      step();
      redirect_valid = 1'b0;
      rsp_auto       = 1'b1;
      check_ifid("flush1", 1'b0, 64'h4, 64'h8, NOP);
      check_req("flush1", 1'b0, 64'h0);
      step();
      step();
      check_req("redir1", 1'b1, 64'h100);
      check("drop1_valid", if_id_valid, 1'b0);
      step();
      step();
      check_ifid("T1", 1'b1, 64'h100, 64'h104, INS_T);
      check_req("req104", 1'b1, 64'h104);

      // ---- redirect in the same cycle as the response ----
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      step();
      redirect_valid = 1'b0;
      check("redir_rsp_valid", if_id_valid, 1'b0);
      check_req("redir2", 1'b1, 64'h100);

      // ---- redirect together with stall while IF/ID holds a real instr ----
      step();
      step();
      check_ifid("T2", 1'b1, 64'h100, 64'h104, INS_T);
      stall = 1'b1;
      step();
      check("stall_T2_valid", if_id_valid, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      check("flush_stall_valid", if_id_valid, 1'b0);
      check("flush_stall_instr", if_id_instr, NOP);
      check_req("redir3", 1'b1, 64'h100);
      step();
      step();
      check_ifid("T3", 1'b1, 64'h100, 64'h104, INS_T);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
